// File: rtl/system_flit_gen_pkg.sv
// Shared types for the system-flit transmit path: node ids, opcodes, flit layout and the flit builder.
`timescale 1ns/1ps
package system_flit_gen_pkg;

   localparam int NODE_ID_W = 8;
   typedef logic [NODE_ID_W-1:0] node_id_t;

   localparam node_id_t BROADCAST_ID = 8'hFF;

   typedef enum logic [1:0] {
      SYS_JOIN_REQ  = 2'd0,
      SYS_ID_ASSIGN = 2'd1,
      SYS_ID_ACK    = 2'd2,
      SYS_HEARTBEAT = 2'd3
   } sys_opcode_t;

   typedef struct packed {
      sys_opcode_t      opcode;
      node_id_t         src;
      node_id_t         dst;
      logic [15:0]      payload;
   } flit_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_JOIN,
      ST_WAIT_ASSIGN,
      ST_SEND_ACK,
      ST_READY,
      ST_FAIL
   } join_state_t;

   function automatic flit_t make_system_flit(input sys_opcode_t opcode, input node_id_t src,
                                              input node_id_t dst, input logic [15:0] payload);
      flit_t f;
      f.opcode  = opcode;
      f.src     = src;
      f.dst     = dst;
      f.payload = payload;
      return f;
   endfunction

endpackage

// File: rtl/system_flit_gen_req_fifo.sv
// Two-entry FIFO of child random ids waiting for an ID_ASSIGN; a push while full is dropped
// unless a pop frees the slot in the same cycle.
`timescale 1ns/1ps
module system_flit_req_fifo
   import system_flit_gen_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  node_id_t push_id,
   input  logic     pop,
   output node_id_t head_id,
   output logic     empty
);

   node_id_t   mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       full;
   logic       push_ok;
   logic       pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head_id = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/system_flit_gen.sv
// System-flit transmitter: node join with retry/timeout, ID_ACK, and ID_ASSIGN answers to children.
// Optional heartbeat flits are built when SYSTEM_FLIT_HEARTBEAT_EN is defined.
`timescale 1ns/1ps
module system_flit_gen
   import system_flit_gen_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY   = 7
`ifdef SYSTEM_FLIT_HEARTBEAT_EN
   ,
   parameter int HB_PERIOD   = 4096
`endif
)(
   input  logic     clk,
   input  logic     rst,
   input  logic     is_root,
   input  node_id_t random_id,
   input  node_id_t this_node_id,
   input  logic     id_valid,
   input  logic     child_req_valid,
   input  node_id_t child_req_random_id,
   input  node_id_t routing_id_counter,
   output logic     routing_id_counter_inc,
   output logic     flit_out_valid,
   input  logic     flit_out_ready,
   output flit_t    flit_out,
   output logic     join_done,
   output logic     join_fail
);

   join_state_t state;
   logic [15:0] timer;
   logic [15:0] timer_dec;
   logic [2:0]  retry;
   logic        transfer;
   logic        fifo_pop;
   logic        fifo_empty;
   node_id_t    fifo_head;

`ifdef SYSTEM_FLIT_HEARTBEAT_EN
   localparam int HB_W = $clog2(HB_PERIOD + 1);
   logic [HB_W-1:0] hb_cnt;
   logic            hb_pending;
`endif

   assign transfer  = flit_out_valid && flit_out_ready;
   assign fifo_pop  = transfer && (state == ST_READY) && (flit_out.opcode == SYS_ID_ASSIGN);
   assign timer_dec = (timer == 16'd0) ? 16'd0 : timer - 16'd1;

   system_flit_req_fifo u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (child_req_valid),
      .push_id (child_req_random_id),
      .pop     (fifo_pop),
      .head_id (fifo_head),
      .empty   (fifo_empty)
   );

   // Handshake: a flit is presented by raising flit_out_valid with flit_out; both hold until
   // flit_out_ready is seen high on a clock edge (transfer = valid & ready), never retracted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= ST_IDLE;
         flit_out_valid         <= 1'b0;
         flit_out               <= '0;
         routing_id_counter_inc <= 1'b0;
         join_done              <= 1'b0;
         join_fail              <= 1'b0;
         timer                  <= 16'd0;
         retry                  <= 3'd0;
`ifdef SYSTEM_FLIT_HEARTBEAT_EN
         hb_cnt                 <= '0;
         hb_pending             <= 1'b0;
`endif
      end else begin
         routing_id_counter_inc <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (is_root) begin
                  state     <= ST_READY;
                  join_done <= 1'b1;
               end else begin
                  state          <= ST_SEND_JOIN;
                  flit_out_valid <= 1'b1;
                  flit_out       <= make_system_flit(SYS_JOIN_REQ, random_id, BROADCAST_ID, 16'h0);
               end
            end
            ST_SEND_JOIN: begin
               if (transfer) begin
                  flit_out_valid <= 1'b0;
                  timer          <= 16'(TIMEOUT_CYC);
                  state          <= ST_WAIT_ASSIGN;
               end
            end
            ST_WAIT_ASSIGN: begin
               // id_valid takes precedence over a timeout landing in the same cycle.
               if (id_valid) begin
                  state          <= ST_SEND_ACK;
                  flit_out_valid <= 1'b1;
                  flit_out       <= make_system_flit(SYS_ID_ACK, this_node_id, BROADCAST_ID, 16'h0);
               end else if (timer_dec == 16'd0) begin
                  timer <= 16'd0;
                  if (retry < 3'(MAX_RETRY)) begin
                     retry          <= retry + 3'd1;
                     state          <= ST_SEND_JOIN;
                     flit_out_valid <= 1'b1;
                     flit_out       <= make_system_flit(SYS_JOIN_REQ, random_id, BROADCAST_ID, 16'h0);
                  end else begin
                     state     <= ST_FAIL;
                     join_fail <= 1'b1;
                  end
               end else begin
                  timer <= timer_dec;
               end
            end
            ST_SEND_ACK: begin
               if (transfer) begin
                  flit_out_valid <= 1'b0;
                  join_done      <= 1'b1;
                  state          <= ST_READY;
               end
            end
            ST_READY: begin
               if (transfer) begin
                  flit_out_valid <= 1'b0;
                  if (flit_out.opcode == SYS_ID_ASSIGN) routing_id_counter_inc <= 1'b1;
               end else if (!flit_out_valid) begin
                  if (!fifo_empty) begin
                     flit_out_valid <= 1'b1;
                     flit_out       <= make_system_flit(SYS_ID_ASSIGN, this_node_id, BROADCAST_ID,
                                                        {fifo_head, routing_id_counter});
                  end
`ifdef SYSTEM_FLIT_HEARTBEAT_EN
                  else if (hb_pending) begin
                     flit_out_valid <= 1'b1;
                     hb_pending     <= 1'b0;
                     flit_out       <= make_system_flit(SYS_HEARTBEAT, this_node_id, BROADCAST_ID, 16'h0);
                  end
`endif
               end
            end
            ST_FAIL: begin
               join_fail <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
`ifdef SYSTEM_FLIT_HEARTBEAT_EN
         // Placed after the FSM so a period ending on the clearing cycle is not lost.
         if (state == ST_READY) begin
            if (hb_cnt == HB_W'(HB_PERIOD - 1)) begin
               hb_cnt     <= '0;
               hb_pending <= 1'b1;
            end else begin
               hb_cnt <= hb_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_system_flit_gen.sv
// Directed bench for system_flit_gen: reset, root join, node join, retry/timeout, ID_ASSIGN, drop, reset mid-flit.
`timescale 1ns/1ps
module tb_system_flit_gen;
   import system_flit_gen_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   logic     is_root;
   node_id_t random_id;
   node_id_t this_node_id;
   logic     id_valid;
   logic     child_req_valid;
   node_id_t child_req_random_id;
   node_id_t routing_id_counter;
   logic     routing_id_counter_inc;
   logic     flit_out_valid;
   logic     flit_out_ready;
   flit_t    flit_out;
   logic     join_done;
   logic     join_fail;

   int errors = 0;
   int checks = 0;
   node_id_t exp_q [$];

   always #5 clk = ~clk;

   system_flit_gen #(.TIMEOUT_CYC(16), .MAX_RETRY(2)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .is_root                (is_root),
      .random_id              (random_id),
      .this_node_id           (this_node_id),
      .id_valid               (id_valid),
      .child_req_valid        (child_req_valid),
      .child_req_random_id    (child_req_random_id),
      .routing_id_counter     (routing_id_counter),
      .routing_id_counter_inc (routing_id_counter_inc),
      .flit_out_valid         (flit_out_valid),
      .flit_out_ready         (flit_out_ready),
      .flit_out               (flit_out),
      .join_done              (join_done),
      .join_fail              (join_fail)
   );

   // Reset pulse; returns on the falling edge where rst is released.
   task automatic apply_reset(input logic root);
      @(negedge clk);
      rst = 1'b1;
      is_root = root;
      id_valid = 1'b0;
      child_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", flit_out_valid); end
      checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit: got %0h expected 0", flit_out); end
      checks++; if (routing_id_counter_inc !== 1'b0) begin errors++; $display("FAIL reset_inc: got %0b expected 0", routing_id_counter_inc); end
      checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL reset_join_done: got %0b expected 0", join_done); end
      checks++; if (join_fail !== 1'b0) begin errors++; $display("FAIL reset_join_fail: got %0b expected 0", join_fail); end
   endtask

   task automatic test_root();
      int bad = 0;
      flit_out_ready = 1'b1;
      apply_reset(1'b1);
      @(negedge clk);
      checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL root_join_done: got %0b expected 1", join_done); end
      repeat (20) begin
         @(negedge clk);
         if (flit_out_valid !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL root_quiet: got %0d valid cycles expected 0", bad); end
   endtask

   task automatic test_join();
      int n = 0;
      random_id = 8'h3A;
      this_node_id = 8'h00;
      flit_out_ready = 1'b1;
      apply_reset(1'b0);
      while (flit_out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      checks++; if (n !== 1) begin errors++; $display("FAIL join_req_latency: got %0d expected 1", n); end
      checks++; if (flit_out.opcode !== SYS_JOIN_REQ) begin errors++; $display("FAIL join_req_op: got %0h expected %0h", flit_out.opcode, SYS_JOIN_REQ); end
      checks++; if (flit_out.src !== 8'h3A) begin errors++; $display("FAIL join_req_src: got %0h expected 3a", flit_out.src); end
      checks++; if (flit_out.dst !== 8'hFF) begin errors++; $display("FAIL join_req_dst: got %0h expected ff", flit_out.dst); end
      @(negedge clk);
      checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL join_req_done: got %0b expected 0", flit_out_valid); end
      repeat (9) @(negedge clk);
      id_valid = 1'b1;
      this_node_id = 8'h05;
      @(negedge clk);
      id_valid = 1'b0;
      n = 0;
      while (flit_out_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      checks++; if (flit_out.opcode !== SYS_ID_ACK) begin errors++; $display("FAIL ack_op: got %0h expected %0h", flit_out.opcode, SYS_ID_ACK); end
      checks++; if (flit_out.src !== 8'h05) begin errors++; $display("FAIL ack_src: got %0h expected 05", flit_out.src); end
      checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL ack_early_done: got %0b expected 0", join_done); end
      @(negedge clk);
      checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL join_done: got %0b expected 1", join_done); end
   endtask

   task automatic test_timeout();
      int idx [$];
      int fail_at = -1;
      int bad = 0;
      int g0;
      int g1;
      int last;
      random_id = 8'h3A;
      flit_out_ready = 1'b1;
      apply_reset(1'b0);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (flit_out_valid === 1'b1) begin
            idx.push_back(c);
            if (flit_out.opcode !== SYS_JOIN_REQ) bad++;
         end
         if (join_fail === 1'b1 && fail_at < 0) fail_at = c;
      end
      g0   = (idx.size() > 1) ? idx[1] - idx[0] : -1;
      g1   = (idx.size() > 2) ? idx[2] - idx[1] : -1;
      last = (idx.size() > 0) ? idx[idx.size()-1] : -100;
      checks++; if (idx.size() !== 3) begin errors++; $display("FAIL retry_count: got %0d expected 3", idx.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL retry_op: got %0d bad flits expected 0", bad); end
      checks++; if (g0 !== 17) begin errors++; $display("FAIL retry_gap0: got %0d expected 17", g0); end
      checks++; if (g1 !== 17) begin errors++; $display("FAIL retry_gap1: got %0d expected 17", g1); end
      checks++; if (fail_at !== last + 17) begin errors++; $display("FAIL fail_time: got %0d expected %0d", fail_at, last + 17); end
      checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL fail_join_done: got %0b expected 0", join_done); end
   endtask

   task automatic test_assign();
      flit_t snap;
      int unstable = 0;
      flit_out_ready = 1'b0;
      this_node_id = 8'h01;
      routing_id_counter = 8'h10;
      apply_reset(1'b1);
      @(negedge clk);
      child_req_valid = 1'b1;
      child_req_random_id = 8'h77;
      @(negedge clk);
      child_req_valid = 1'b0;
      @(negedge clk);
      snap = flit_out;
      routing_id_counter = 8'h20;
      checks++; if (flit_out_valid !== 1'b1) begin errors++; $display("FAIL assign_valid: got %0b expected 1", flit_out_valid); end
      checks++; if (snap.opcode !== SYS_ID_ASSIGN) begin errors++; $display("FAIL assign_op: got %0h expected %0h", snap.opcode, SYS_ID_ASSIGN); end
      checks++; if (snap.src !== 8'h01) begin errors++; $display("FAIL assign_src: got %0h expected 01", snap.src); end
      checks++; if (snap.dst !== 8'hFF) begin errors++; $display("FAIL assign_dst: got %0h expected ff", snap.dst); end
      checks++; if (snap.payload !== 16'h7710) begin errors++; $display("FAIL assign_payload: got %0h expected 7710", snap.payload); end
      repeat (5) begin
         @(negedge clk);
         if (flit_out_valid !== 1'b1 || flit_out !== snap) unstable++;
      end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL assign_stable: got %0d unstable cycles expected 0", unstable); end
      flit_out_ready = 1'b1;
      @(negedge clk);
      checks++; if (routing_id_counter_inc !== 1'b1) begin errors++; $display("FAIL inc_pulse: got %0b expected 1", routing_id_counter_inc); end
      checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL assign_drop_valid: got %0b expected 0", flit_out_valid); end
      @(negedge clk);
      checks++; if (routing_id_counter_inc !== 1'b0) begin errors++; $display("FAIL inc_single: got %0b expected 0", routing_id_counter_inc); end
      flit_out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int assigns = 0;
      int incs = 0;
      node_id_t exp;
      flit_out_ready = 1'b0;
      routing_id_counter = 8'h20;
      apply_reset(1'b1);
      @(negedge clk);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         child_req_valid = 1'b1;
         child_req_random_id = 8'hA1 + 8'(i);
         if (exp_q.size() < 2) exp_q.push_back(child_req_random_id);
         @(negedge clk);
      end
      child_req_valid = 1'b0;
      flit_out_ready = 1'b1;
      repeat (20) begin
         if (routing_id_counter_inc === 1'b1) incs++;
         if (flit_out_valid === 1'b1 && flit_out_ready === 1'b1) begin
            assigns++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            checks++; if (flit_out.payload[15:8] !== exp) begin errors++; $display("FAIL b2b_child_id: got %0h expected %0h", flit_out.payload[15:8], exp); end
         end
         @(negedge clk);
      end
      checks++; if (assigns !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", assigns); end
      checks++; if (incs !== 2) begin errors++; $display("FAIL b2b_incs: got %0d expected 2", incs); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      random_id = 8'h3A;
      flit_out_ready = 1'b0;
      apply_reset(1'b0);
      @(negedge clk);
      checks++; if (flit_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b expected 1", flit_out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_clear: got %0b expected 0", flit_out_valid); end
      checks++; if (flit_out !== '0) begin errors++; $display("FAIL mid_flit_clear: got %0h expected 0", flit_out); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (flit_out_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid: got %0b expected 1", flit_out_valid); end
      checks++; if (flit_out.opcode !== SYS_JOIN_REQ) begin errors++; $display("FAIL mid_restart_op: got %0h expected %0h", flit_out.opcode, SYS_JOIN_REQ); end
   endtask

   initial begin
      rst = 1'b1;
      is_root = 1'b0;
      random_id = 8'h00;
      this_node_id = 8'h00;
      id_valid = 1'b0;
      child_req_valid = 1'b0;
      child_req_random_id = 8'h00;
      routing_id_counter = 8'h00;
      flit_out_ready = 1'b0;
      test_reset();
      test_root();
      test_join();
      test_timeout();
      test_assign();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
